// File: rtl/pow_5_res_collector.sv
// Pairs pow_5 pipeline results with their queued arguments, checks res == arg^5 and
// buffers the {arg, res} pairs in an output FIFO with sticky error reporting.
module pow_5_res_collector #(
    parameter int unsigned w         = 8,
    parameter int unsigned TAG_DEPTH = 8,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arg_vld,
    input  logic [w-1:0]     arg,
    input  logic             res_vld,
    input  logic [5*w-1:0]   res,
    input  logic             rd_en,
    output logic             out_vld,
    output logic [w-1:0]     out_arg,
    output logic [5*w-1:0]   out_res,
    output logic             out_full,
    output logic             mismatch,
    output logic             orphan,
    output logic             overflow,
    output logic [7:0]       err_cnt
);

    localparam int unsigned RW  = 5 * w;
    localparam int unsigned TAW = $clog2(TAG_DEPTH);
    localparam int unsigned OAW = $clog2(OUT_DEPTH);

    logic [w-1:0]  tag_mem [TAG_DEPTH];
    logic [TAW:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic          tag_empty, tag_full, tag_we;

    logic [w-1:0]  out_arg_mem [OUT_DEPTH];
    logic [RW-1:0] out_res_mem [OUT_DEPTH];
    logic [OAW:0]  out_wr_q, out_rd_q;
    logic          out_empty, out_full_int, out_pop, out_we, out_ovf;

    logic          pair_vld, pair_bad, orphan_set, tag_ovf;
    logic [w-1:0]  pair_tag;
    logic [RW-1:0] t_ext, p2, p4, expected;

    logic          mismatch_q, orphan_q, overflow_q;
    logic [7:0]    err_cnt_q;

    assign tag_empty = (tag_wr_q == tag_rd_q);
    assign tag_full  = (tag_wr_q[TAW] != tag_rd_q[TAW]) &&
                       (tag_wr_q[TAW-1:0] == tag_rd_q[TAW-1:0]);

    always_comb begin
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        tag_we     = 1'b0;
        pair_vld   = 1'b0;
        pair_tag   = tag_mem[tag_rd_q[TAW-1:0]];
        orphan_set = 1'b0;
        tag_ovf    = 1'b0;
        if (res_vld) begin
            if (!tag_empty) begin
                // Pop reads the pre-push head, so push+pop is safe even when full.
                pair_vld = 1'b1;
                tag_rd_d = tag_rd_q + 1'b1;
                if (arg_vld) begin
                    tag_we   = 1'b1;
                    tag_wr_d = tag_wr_q + 1'b1;
                end
            end else if (arg_vld) begin
                pair_vld = 1'b1;
                pair_tag = arg;
            end else begin
                orphan_set = 1'b1;
            end
        end else if (arg_vld) begin
            if (tag_full) begin
                tag_ovf = 1'b1;
            end else begin
                tag_we   = 1'b1;
                tag_wr_d = tag_wr_q + 1'b1;
            end
        end
    end

    // Truncated products give the same low RW bits as the full-precision power.
    always_comb begin
        t_ext    = RW'(pair_tag);
        p2       = t_ext * t_ext;
        p4       = p2 * p2;
        expected = p4 * t_ext;
    end

    assign pair_bad = pair_vld && (res != expected);

    assign out_empty    = (out_wr_q == out_rd_q);
    assign out_full_int = (out_wr_q[OAW] != out_rd_q[OAW]) &&
                          (out_wr_q[OAW-1:0] == out_rd_q[OAW-1:0]);
    assign out_pop      = rd_en && !out_empty;
    assign out_we       = pair_vld && (!out_full_int || out_pop);
    assign out_ovf      = pair_vld && out_full_int && !out_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            out_wr_q   <= '0;
            out_rd_q   <= '0;
            mismatch_q <= 1'b0;
            orphan_q   <= 1'b0;
            overflow_q <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
            if (out_we) begin
                out_wr_q <= out_wr_q + 1'b1;
            end
            if (out_pop) begin
                out_rd_q <= out_rd_q + 1'b1;
            end
            if (pair_bad) begin
                mismatch_q <= 1'b1;
            end
            if (pair_bad && (err_cnt_q != 8'hff)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (orphan_set) begin
                orphan_q <= 1'b1;
            end
            if (tag_ovf || out_ovf) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && tag_we) begin
            tag_mem[tag_wr_q[TAW-1:0]] <= arg;
        end
        if (rst_n && out_we) begin
            out_arg_mem[out_wr_q[OAW-1:0]] <= pair_tag;
            out_res_mem[out_wr_q[OAW-1:0]] <= res;
        end
    end

    assign out_vld  = !out_empty;
    assign out_arg  = out_arg_mem[out_rd_q[OAW-1:0]];
    assign out_res  = out_res_mem[out_rd_q[OAW-1:0]];
    assign out_full = out_full_int;
    assign mismatch = mismatch_q;
    assign orphan   = orphan_q;
    assign overflow = overflow_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_pow_5_res_collector.sv
// Scoreboard bench for pow_5_res_collector: expected pairs are queued when a result is
// driven and compared in order as the consumer pops them.
module tb_pow_5_res_collector;

    localparam int W  = 8;
    localparam int RW = 40;

    logic          clk = 1'b0;
    logic          rst_n, arg_vld, res_vld, rd_en;
    logic [W-1:0]  arg;
    logic [RW-1:0] res;
    logic          out_vld, out_full, mismatch, orphan, overflow;
    logic [W-1:0]  out_arg;
    logic [RW-1:0] out_res;
    logic [7:0]    err_cnt;

    logic [W+RW-1:0] exp_q[$];
    logic [W+RW-1:0] mon_e;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pow_5_res_collector #(.w(W), .TAG_DEPTH(8), .OUT_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld), .arg(arg), .res_vld(res_vld),
        .res(res), .rd_en(rd_en), .out_vld(out_vld), .out_arg(out_arg),
        .out_res(out_res), .out_full(out_full), .mismatch(mismatch), .orphan(orphan),
        .overflow(overflow), .err_cnt(err_cnt)
    );

    function automatic logic [RW-1:0] pow5(input logic [W-1:0] a);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < 5; i++) p = p * 64'(a);
        return p[RW-1:0];
    endfunction

    // Scoreboard consumer: a pop happens at the next rising edge when out_vld && rd_en.
    always @(negedge clk) begin
        if (rst_n && out_vld && rd_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL pop_pair: got %0d/%0d want no pair", out_arg, out_res);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_arg, out_res} !== mon_e)
                    $display("FAIL pop_pair: got %0d/%0d want %0d/%0d", out_arg, out_res,
                             mon_e[W+RW-1:RW], mon_e[RW-1:0]);
                else n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arg_vld = 1'b0; res_vld = 1'b0; rd_en = 1'b0; arg = '0; res = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic drain(input int n);
        rd_en = 1'b1;
        repeat (n) tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({out_vld, out_full, mismatch, orphan, overflow} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {out_vld, out_full, mismatch, orphan, overflow});
        else n_pass++;
        n_checks++;
        if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
        else n_pass++;
    endtask

    task automatic test_basic();
        arg_vld = 1'b1; arg = 8'd3;
        tick();
        arg_vld = 1'b0;
        repeat (3) tick();
        res_vld = 1'b1; res = 40'd243;
        exp_q.push_back({8'd3, 40'd243});
        tick();
        res_vld = 1'b0;
        n_checks++;
        if ({out_vld, out_arg, out_res, mismatch} !== {1'b1, 8'd3, 40'd243, 1'b0})
            $display("FAIL basic_pair: got vld=%b %0d/%0d mm=%b want vld=1 3/243 mm=0",
                     out_vld, out_arg, out_res, mismatch);
        else n_pass++;
        drain(1);
        n_checks++;
        if (out_vld !== 1'b0) $display("FAIL basic_drained: got %b want 0", out_vld);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [W-1:0]  args [3] = '{8'd2, 8'd5, 8'd255};
        logic [RW-1:0] ress [3] = '{40'd32, 40'd3125, 40'd1078203909375};
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            arg_vld = 1'b1; arg = args[i];
            tick();
        end
        arg_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            res_vld = 1'b1; res = ress[i];
            exp_q.push_back({args[i], ress[i]});
            tick();
        end
        res_vld = 1'b0;
        repeat (3) tick();
        rd_en = 1'b0;
        n_checks++;
        if ({err_cnt, mismatch} !== 9'd0)
            $display("FAIL stream_errors: got err_cnt=%0d mm=%b want 0/0", err_cnt, mismatch);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL stream_left: got %0d want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_mismatch();
        logic [W-1:0] a;
        do_reset();
        arg_vld = 1'b1; arg = 8'd4;
        tick();
        arg_vld = 1'b0;
        res_vld = 1'b1; res = 40'd1000;
        exp_q.push_back({8'd4, 40'd1000});
        tick();
        res_vld = 1'b0;
        n_checks++;
        if ({out_vld, mismatch, err_cnt} !== {1'b1, 1'b1, 8'd1})
            $display("FAIL mm_single: got vld=%b mm=%b err=%0d want 1/1/1",
                     out_vld, mismatch, err_cnt);
        else n_pass++;
        drain(1);
        rd_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = 8'(i);
            arg_vld = 1'b1; arg = a; res_vld = 1'b1; res = pow5(a) + 40'd1;
            exp_q.push_back({a, pow5(a) + 40'd1});
            tick();
        end
        arg_vld = 1'b0; res_vld = 1'b0;
        repeat (2) tick();
        rd_en = 1'b0;
        n_checks++;
        if (err_cnt !== 8'd255) $display("FAIL mm_saturate: got %0d want 255", err_cnt);
        else n_pass++;
        n_checks++;
        if ({overflow, exp_q.size() == 0} !== 2'b01)
            $display("FAIL mm_flow: got ovf=%b left=%0d want 0/0", overflow, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_orphan();
        do_reset();
        res_vld = 1'b1; res = 40'd5;
        tick();
        res_vld = 1'b0;
        n_checks++;
        if ({orphan, out_vld} !== 2'b10)
            $display("FAIL orphan_set: got orphan=%b vld=%b want 1/0", orphan, out_vld);
        else n_pass++;
        arg_vld = 1'b1; arg = 8'd7; res_vld = 1'b1; res = 40'd16807;
        exp_q.push_back({8'd7, 40'd16807});
        tick();
        arg_vld = 1'b0; res_vld = 1'b0;
        n_checks++;
        if ({out_vld, out_arg, out_res, mismatch} !== {1'b1, 8'd7, 40'd16807, 1'b0})
            $display("FAIL bypass_pair: got vld=%b %0d/%0d mm=%b want vld=1 7/16807 mm=0",
                     out_vld, out_arg, out_res, mismatch);
        else n_pass++;
        drain(1);
        n_checks++;
        if (out_vld !== 1'b0) $display("FAIL bypass_drained: got %b want 0", out_vld);
        else n_pass++;
    endtask

    task automatic test_out_full();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            arg_vld = 1'b1; arg = 8'(i); res_vld = 1'b1; res = pow5(8'(i));
            if (i <= 4) exp_q.push_back({8'(i), pow5(8'(i))});
            tick();
        end
        arg_vld = 1'b0; res_vld = 1'b0;
        n_checks++;
        if ({out_full, overflow, mismatch} !== 3'b110)
            $display("FAIL out_full_drop: got full=%b ovf=%b mm=%b want 1/1/0",
                     out_full, overflow, mismatch);
        else n_pass++;
        rd_en = 1'b1; arg_vld = 1'b1; arg = 8'd6; res_vld = 1'b1; res = 40'd7776;
        exp_q.push_back({8'd6, 40'd7776});
        tick();
        rd_en = 1'b0; arg_vld = 1'b0; res_vld = 1'b0;
        n_checks++;
        if (out_full !== 1'b1) $display("FAIL full_push_pop: got %b want 1", out_full);
        else n_pass++;
        drain(4);
        n_checks++;
        if ({out_vld, exp_q.size() == 0} !== 2'b01)
            $display("FAIL full_drained: got vld=%b left=%0d want 0/0", out_vld, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] order [8] = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd20};
        do_reset();
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            arg_vld = 1'b1; arg = 8'(10 + i);
            tick();
        end
        arg_vld = 1'b1; arg = 8'd20; res_vld = 1'b1; res = pow5(8'd10);
        exp_q.push_back({8'd10, pow5(8'd10)});
        tick();
        arg_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            res = pow5(order[i]);
            exp_q.push_back({order[i], pow5(order[i])});
            tick();
        end
        res_vld = 1'b0;
        repeat (2) tick();
        rd_en = 1'b0;
        n_checks++;
        if ({orphan, overflow, mismatch} !== 3'b000)
            $display("FAIL tag_full_push_pop: got orphan=%b ovf=%b mm=%b want 0/0/0",
                     orphan, overflow, mismatch);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL b2b_left: got %0d want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_tag_reset();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            arg_vld = 1'b1; arg = 8'(i + 1);
            tick();
        end
        arg_vld = 1'b0;
        n_checks++;
        if ({overflow, orphan} !== 2'b10)
            $display("FAIL tag_overflow: got ovf=%b orphan=%b want 1/0", overflow, orphan);
        else n_pass++;
        rst_n = 1'b0; res_vld = 1'b1; res = pow5(8'd1);
        tick();
        rst_n = 1'b1; res_vld = 1'b0;
        n_checks++;
        if ({out_vld, out_full, mismatch, orphan, overflow, err_cnt} !== 13'd0)
            $display("FAIL midstream_reset: got %b want all zero",
                     {out_vld, out_full, mismatch, orphan, overflow, err_cnt});
        else n_pass++;
        res_vld = 1'b1; res = pow5(8'd1);
        tick();
        res_vld = 1'b0;
        n_checks++;
        if ({orphan, out_vld} !== 2'b10)
            $display("FAIL post_reset_orphan: got orphan=%b vld=%b want 1/0", orphan, out_vld);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; arg_vld = 1'b0; res_vld = 1'b0; rd_en = 1'b0; arg = '0; res = '0;
        tick();
        test_reset();
        test_basic();
        test_stream();
        test_mismatch();
        test_orphan();
        test_out_full();
        test_back_to_back();
        test_tag_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
